mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-port arbiter sharing the single-ported 64 KiB mem block between requesters.
//   The mem block decodes ROM, RAM and the fff8-ffff I/O window.
//   Port 0 is the CPU; port 1 is the DMA/debug loader.
//   Owns mem's addr, data_in and write_en. Returns mem's data_out to the winning port.
//   Sits between the requesters and mem.
// PARAMETERS
//   ACCESS_CYCLES  1  cycles mem_addr is held before read data is sampled (>=1)
// PORTS
//   clk         in   1   system clock; all state on posedge
//   reset       in   1   asynchronous, active-low reset
//   m0_req      in   1   port 0 request; held with m0_we/addr/wdata until m0_ack
//   m0_we       in   1   port 0 write (1) / read (0)
//   m0_addr     in   16  port 0 byte address
//   m0_wdata    in   8   port 0 write data
//   m0_ack      out  1   port 0 one-cycle completion pulse
//   m0_rdata    out  8   port 0 read data, valid while m0_ack=1, held after
//   m1_*        ---  --  identical set for port 1 (req, we, addr, wdata, ack, rdata)
//   mem_addr    out  16  to mem addr
//   mem_wdata   out  8   to mem data_in
//   mem_we      out  1   to mem write_en
//   mem_rdata   in   8   from mem data_out (updated on negedge)
//   owner       out  1   port currently or last granted (0/1)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0,
//     m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, owner=0, cnt=0.
//   FSM states: IDLE -> ACCESS -> ACK -> IDLE.
//   IDLE:
//     - If no request is pending, stay in IDLE.
//     - Otherwise select a winner (see CONFIGURATION).
//     - Register the winner's addr/wdata into mem_addr/mem_wdata.
//     - Set mem_we = winner's we and set owner.
//     - Load cnt = ACCESS_CYCLES-1 and go to ACCESS.
//   ACCESS:
//     - mem_we is high for the first ACCESS cycle only, so a write commits at exactly one posedge.
//     - mem_we is cleared on that edge.
//     - mem_addr stays stable for the whole of ACCESS.
//     - At cnt==0: latch mem_rdata into the owner's rdata (reads only; writes keep the old rdata).
//       Then pulse the owner's ack and go to ACK. Otherwise decrement cnt.
//   ACK:
//     - owner's ack=1 for exactly this cycle; it is cleared on the next edge.
//     - Return to IDLE; the request is not re-sampled in ACK.
//     - A requester that sees ack drops or changes its req on the same edge.
//     - The earliest next grant is the cycle after ACK.
//   Latency:
//     - req seen in IDLE -> ack asserted ACCESS_CYCLES+1 cycles later.
//     - Throughput is one access per ACCESS_CYCLES+2 cycles.
//   Only the owner's ack may ever be high; never both.
//   A non-owner's req is ignored until the FSM returns to IDLE; its inputs are not sampled.
//   A req dropped mid-access is ignored: the access completes and ack still pulses.
//   Reset mid-access aborts it: mem_we falls immediately; a partially sequenced write may be lost.
//   Addresses fff8-ffff are passed through unmodified; I/O side effects are owned by mem.
// CONFIGURATION
//   ROUND_ROBIN_EN defined:
//     - On a tie (both req in IDLE), the port that is not owner wins.
//     - No port waits for more than one access by the other port.
//   ROUND_ROBIN_EN undefined:
//     - Fixed priority: m0 always wins ties; m1 may starve.
//   Single requests are granted immediately in both builds.
// TESTING
//   T1 reset=0 mid-ACCESS of a m0 write -> mem_we=0 immediately; all acks=0; state IDLE.
//      After release, m1 read of 0x8010 completes normally.
//   T2 m0 write 0x8010<=0xA5, then m0 read 0x8010 (ACCESS_CYCLES=1):
//      - mem_we high for exactly 1 cycle.
//      - First ack at cycle 2 after req.
//      - Second ack with m0_rdata=0xA5.
//   T3 m1 write 0xfff9<=0x3C, then m1 read 0xfff9:
//      - m1_rdata=0x3C.
//      - m0_ack stays 0 throughout.
//   T4 m0 and m1 both reading continuously:
//      - Without ROUND_ROBIN_EN: only m0_ack pulses over 20 cycles.
//      - With ROUND_ROBIN_EN: acks alternate m0, m1, m0, m1.
//   T5 ACCESS_CYCLES=3, m1 read of ROM 0x0004:
//      - mem_addr stable for 3 cycles; ack at req+4.
//      - m1_rdata equals ROM[4].
//   T6 m0 drops req the cycle after grant:
//      - Access still completes; m0_ack pulses once.
//      - Next IDLE grants pending m1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Single requester port of the memory arbiter: request/ack handshake plus address and data.
// The requester is the master; the arbiter is the slave.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-ported mem: ack ACCESS_CYCLES+1 cycles after grant, one access per ACCESS_CYCLES+2.
// Requests are held until ack; losers wait. ROUND_ROBIN_EN selects round-robin ties, otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave m0,
  mem_arbiter_if.slave m1,
  output logic [15:0]  mem_addr,
  output logic [7:0]   mem_wdata,
  output logic         mem_we,
  input  logic [7:0]   mem_rdata,
  output logic         owner
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_we_q, op_we_d;
  logic [15:0]      addr_d;
  logic [7:0]       wdata_d;
  logic             we_d;
  logic             owner_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic [7:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic             any_req;
  logic             pick_m1;

  assign any_req = m0.req | m1.req;

`ifdef ROUND_ROBIN_EN
  // On a tie the port that did not own the last access goes next.
  assign pick_m1 = m1.req & (~m0.req | ~owner);
`else
  assign pick_m1 = m1.req & ~m0.req;
`endif

  assign m0.ack   = ack0_q;
  assign m1.ack   = ack1_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    we_d     = 1'b0;
    owner_d  = owner;
    op_we_d  = op_we_q;
    cnt_d    = cnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d  = pick_m1 ? m1.addr  : m0.addr;
          wdata_d = pick_m1 ? m1.wdata : m0.wdata;
          we_d    = pick_m1 ? m1.we    : m0.we;
          op_we_d = we_d;
          owner_d = pick_m1;
          cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
        end
      end
      ACCESS: begin
        // mem_we already dropped after the first ACCESS edge; op_we_q remembers the direction.
        if (cnt_q == '0) begin
          if (!op_we_q) begin
            if (owner) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
          ack0_d = ~owner;
          ack1_d = owner;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      owner     <= 1'b0;
      op_we_q   <= 1'b0;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= 8'h00;
      rdata1_q  <= 8'h00;
    end else begin
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      owner     <= owner_d;
      op_we_q   <= op_we_d;
      cnt_q     <= cnt_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on ACCESS_CYCLES=1 and 3 instances plus a randomized two-port run
// against a transaction-level memory scoreboard. Honours ROUND_ROBIN_EN.
module tb_mem_arbiter;
  localparam int AC_A = 1;
  localparam int AC_B = 3;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if a0 ();
  mem_arbiter_if a1 ();
  mem_arbiter_if b0 ();
  mem_arbiter_if b1 ();

  logic [15:0] mem_addr_a, mem_addr_b;
  logic [7:0]  mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic        mem_we_a, mem_we_b, owner_a, owner_b;

  mem_arbiter #(.ACCESS_CYCLES(AC_A)) u_dut_a (
    .clk(clk), .reset(reset), .m0(a0), .m1(a1),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .mem_rdata(mem_rdata_a), .owner(owner_a)
  );

  mem_arbiter #(.ACCESS_CYCLES(AC_B)) u_dut_b (
    .clk(clk), .reset(reset), .m0(b0), .m1(b1),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_rdata(mem_rdata_b), .owner(owner_b)
  );

  // Environment memory: ROM below 0x8000 (fixed pattern), RAM/IO above, data_out updated on negedge.
  logic [7:0] ram_a [int];
  logic [7:0] ram_b [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_read_a(input logic [15:0] a);
    if (a < 16'h8000) return rom_val(a);
    if (ram_a.exists(int'(a))) return ram_a[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [7:0] mem_read_b(input logic [15:0] a);
    if (a < 16'h8000) return rom_val(a);
    if (ram_b.exists(int'(a))) return ram_b[int'(a)];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_we_a && mem_addr_a >= 16'h8000) ram_a[int'(mem_addr_a)] = mem_wdata_a;
    if (mem_we_b && mem_addr_b >= 16'h8000) ram_b[int'(mem_addr_b)] = mem_wdata_b;
  end

  always @(negedge clk) begin
    mem_rdata_a <= mem_read_a(mem_addr_a);
    mem_rdata_b <= mem_read_b(mem_addr_b);
  end

  // Scoreboard view of memory: what each completed access says the contents should be.
  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (a < 16'h8000) return rom_val(a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 8'h00;
  endfunction

  task automatic drive(input int p, input logic r, input logic w, input logic [15:0] ad, input logic [7:0] d);
    if (p == 0) begin
      a0.req = r; a0.we = w; a0.addr = ad; a0.wdata = d;
    end else begin
      a1.req = r; a1.we = w; a1.addr = ad; a1.wdata = d;
    end
  endtask

  function automatic logic port_ack(input int p);
    return (p == 0) ? a0.ack : a1.ack;
  endfunction

  function automatic logic [7:0] port_rdata(input int p);
    return (p == 0) ? a0.rdata : a1.rdata;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_addr_a, mem_wdata_a, mem_we_a, owner_a} !== 26'h0) begin
      errors++; $display("FAIL reset_mem_a: got %h, expected 0", {mem_addr_a, mem_wdata_a, mem_we_a, owner_a});
    end
    checks++;
    if ({a0.ack, a1.ack, a0.rdata, a1.rdata} !== 18'h0) begin
      errors++; $display("FAIL reset_ports_a: got %h, expected 0", {a0.ack, a1.ack, a0.rdata, a1.rdata});
    end
    checks++;
    if ({mem_addr_b, mem_wdata_b, mem_we_b, owner_b, b0.ack, b1.ack, b0.rdata, b1.rdata} !== 44'h0) begin
      errors++; $display("FAIL reset_b: got %h, expected 0",
                         {mem_addr_b, mem_wdata_b, mem_we_b, owner_b, b0.ack, b1.ack, b0.rdata, b1.rdata});
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h8010, 8'h77);
    @(negedge clk);
    checks++;
    if (mem_we_a !== 1'b1) begin
      errors++; $display("FAIL t1_we_before_reset: got %b, expected 1", mem_we_a);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_we_a, a0.ack, a1.ack, owner_a, mem_addr_a} !== 20'h0) begin
      errors++; $display("FAIL t1_abort: got %h, expected 0", {mem_we_a, a0.ack, a1.ack, owner_a, mem_addr_a});
    end
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1'b1, 1'b0, 16'h8010, 8'h0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!a1.ack && cyc < 20);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    checks++;
    if (cyc != AC_A + 1) begin
      errors++; $display("FAIL t1_latency_after_reset: got %0d, expected %0d", cyc, AC_A + 1);
    end
    checks++;
    if (a1.rdata !== ref_read(16'h8010)) begin
      errors++; $display("FAIL t1_rdata: got %h, expected %h", a1.rdata, ref_read(16'h8010));
    end
  endtask

  task automatic test_write_read();
    int cyc, we_cnt;
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h8010, 8'hA5);
    cyc = 0; we_cnt = 0;
    do begin @(negedge clk); cyc++; if (mem_we_a) we_cnt++; end while (!a0.ack && cyc < 20);
    checks++;
    if (cyc != AC_A + 1) begin
      errors++; $display("FAIL t2_write_latency: got %0d, expected %0d", cyc, AC_A + 1);
    end
    checks++;
    if (we_cnt != 1) begin
      errors++; $display("FAIL t2_we_width: got %0d, expected 1", we_cnt);
    end
    ref_mem[int'(16'h8010)] = 8'hA5;
    drive(0, 1'b1, 1'b0, 16'h8010, 8'h00);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!a0.ack && cyc < 20);
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
    checks++;
    if (cyc != AC_A + 2) begin
      errors++; $display("FAIL t2_back_to_back: got %0d, expected %0d", cyc, AC_A + 2);
    end
    checks++;
    if (a0.rdata !== 8'hA5) begin
      errors++; $display("FAIL t2_rdata: got %h, expected a5", a0.rdata);
    end
  endtask

  task automatic test_io_window();
    int cyc, m0_acks;
    logic [15:0] seen_addr;
    repeat (3) @(negedge clk);
    m0_acks = 0;
    drive(1, 1'b1, 1'b1, 16'hfff9, 8'h3C);
    cyc = 0; seen_addr = 16'h0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) seen_addr = mem_addr_a;
      if (a0.ack) m0_acks++;
    end while (!a1.ack && cyc < 20);
    checks++;
    if (seen_addr !== 16'hfff9) begin
      errors++; $display("FAIL t3_addr_passthrough: got %h, expected fff9", seen_addr);
    end
    ref_mem[int'(16'hfff9)] = 8'h3C;
    drive(1, 1'b1, 1'b0, 16'hfff9, 8'h00);
    cyc = 0;
    do begin @(negedge clk); cyc++; if (a0.ack) m0_acks++; end while (!a1.ack && cyc < 20);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    checks++;
    if (a1.rdata !== 8'h3C) begin
      errors++; $display("FAIL t3_rdata: got %h, expected 3c", a1.rdata);
    end
    checks++;
    if (m0_acks != 0) begin
      errors++; $display("FAIL t3_m0_ack_quiet: got %0d acks, expected 0", m0_acks);
    end
    checks++;
    if (cyc != AC_A + 2) begin
      errors++; $display("FAIL t3_read_latency: got %0d, expected %0d", cyc, AC_A + 2);
    end
  endtask

  task automatic test_contention();
    int seq[$];
    int bad, n_exp;
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h8010, 8'h0);
    drive(1, 1'b1, 1'b0, 16'hfff9, 8'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a0.ack) seq.push_back(0);
      if (a1.ack) seq.push_back(1);
    end
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    // Acks land at negedges AC+1, AC+1+(AC+2), ... within the 20-cycle window.
    n_exp = (20 - (AC_A + 1)) / (AC_A + 2) + 1;
    checks++;
    if (seq.size() != n_exp) begin
      errors++; $display("FAIL t4_ack_count: got %0d, expected %0d", seq.size(), n_exp);
    end
    bad = 0;
    foreach (seq[i]) if (seq[i] != (RR ? (i % 2) : 0)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL t4_ack_order: got %0d out-of-order acks, expected 0", bad);
    end
    checks++;
    if ({a0.rdata, a1.rdata} !== {8'hA5, 8'h3C}) begin
      errors++; $display("FAIL t4_rdata: got %h, expected a53c", {a0.rdata, a1.rdata});
    end
  endtask

  task automatic test_access_cycles();
    int cyc, stable, b0_acks, we_cnt;
    repeat (3) @(negedge clk);
    b1.req = 1'b1; b1.we = 1'b0; b1.addr = 16'h0004; b1.wdata = 8'h00;
    cyc = 0; stable = 0; b0_acks = 0; we_cnt = 0;
    do begin
      @(negedge clk); cyc++;
      if (!b1.ack && mem_addr_b === 16'h0004) stable++;
      if (b0.ack) b0_acks++;
      if (mem_we_b) we_cnt++;
    end while (!b1.ack && cyc < 20);
    b1.req = 1'b0;
    checks++;
    if (cyc != AC_B + 1) begin
      errors++; $display("FAIL t5_latency: got %0d, expected %0d", cyc, AC_B + 1);
    end
    checks++;
    if (stable != AC_B) begin
      errors++; $display("FAIL t5_addr_stable: got %0d cycles, expected %0d", stable, AC_B);
    end
    checks++;
    if (b1.rdata !== rom_val(16'h0004)) begin
      errors++; $display("FAIL t5_rom_rdata: got %h, expected %h", b1.rdata, rom_val(16'h0004));
    end
    checks++;
    if (b0_acks + we_cnt != 0) begin
      errors++; $display("FAIL t5_quiet: got %0d stray acks/writes, expected 0", b0_acks + we_cnt);
    end
  endtask

  task automatic test_drop_req();
    int m0_cnt, m0_cyc, m1_cyc;
    logic own_at;
    repeat (3) @(negedge clk);
    m0_cnt = 0; m0_cyc = -1; m1_cyc = -1; own_at = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h8010, 8'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b1, 1'b0, 16'hfff9, 8'h0);
      end
      if (a0.ack) begin m0_cnt++; m0_cyc = i; end
      if (a1.ack) begin m1_cyc = i; own_at = owner_a; drive(1, 1'b0, 1'b0, 16'h0, 8'h0); end
    end
    checks++;
    if (m0_cnt != 1 || m0_cyc != AC_A + 1) begin
      errors++; $display("FAIL t6_m0_ack: got %0d acks at %0d, expected 1 at %0d", m0_cnt, m0_cyc, AC_A + 1);
    end
    checks++;
    if (m1_cyc != 2 * AC_A + 3) begin
      errors++; $display("FAIL t6_m1_grant: got ack at %0d, expected %0d", m1_cyc, 2 * AC_A + 3);
    end
    checks++;
    if (own_at !== 1'b1) begin
      errors++; $display("FAIL t6_owner: got %b, expected 1", own_at);
    end
    checks++;
    if ({a0.rdata, a1.rdata} !== {ref_read(16'h8010), ref_read(16'hfff9)}) begin
      errors++; $display("FAIL t6_rdata: got %h, expected %h", {a0.rdata, a1.rdata},
                         {ref_read(16'h8010), ref_read(16'hfff9)});
    end
  endtask

  task automatic run_port(input int p, input int ntx);
    int gap, cyc, kind;
    logic w;
    logic [15:0] ad;
    logic [7:0] d, got, exp;
    for (int n = 0; n < ntx; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      kind = int'($urandom_range(0, 2));
      w = 1'b0;
      if (kind == 0)      ad = 16'($urandom_range(0, 16'h7fff));
      else if (kind == 1) ad = 16'h8000 + 16'($urandom_range(0, 15));
      else                ad = 16'hfff8 + 16'($urandom_range(0, 7));
      if (kind != 0) w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      drive(p, 1'b1, w, ad, d);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!port_ack(p) && cyc < 300);
      checks++;
      if (!port_ack(p)) begin
        errors++; $display("FAIL rand_timeout: port %0d got no ack in %0d cycles, expected ack", p, cyc);
        drive(p, 1'b0, 1'b0, 16'h0, 8'h0);
        break;
      end
      if (w) begin
        ref_mem[int'(ad)] = d;
      end else begin
        got = port_rdata(p);
        exp = ref_read(ad);
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL rand_rdata: port %0d addr %h got %h, expected %h", p, ad, got, exp);
        end
      end
      // Port 0 always, and both ports under round-robin, wait at most one foreign access.
      if (p == 0 || RR) begin
        checks++;
        if (cyc > 2 * AC_A + 3) begin
          errors++; $display("FAIL rand_latency: port %0d got %0d cycles, expected <= %0d", p, cyc, 2 * AC_A + 3);
        end
      end
      drive(p, 1'b0, 1'b0, 16'h0, 8'h0);
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    repeat (3) @(negedge clk);
    fork
      begin
        fork
          run_port(0, 40);
          run_port(1, 40);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (a0.ack || a1.ack) begin
            checks++;
            if (a0.ack && a1.ack) begin
              errors++; $display("FAIL rand_ack_exclusive: got both acks, expected one");
            end else if (owner_a !== a1.ack) begin
              errors++; $display("FAIL rand_ack_owner: got owner %b, expected %b", owner_a, a1.ack);
            end
          end
        end
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = 16'h0; b0.wdata = 8'h0;
    b1.req = 1'b0; b1.we = 1'b0; b1.addr = 16'h0; b1.wdata = 8'h0;
    test_reset();
    test_reset_mid_access();
    test_write_read();
    test_io_window();
    test_contention();
    test_access_cycles();
    test_drop_req();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
